// File: rtl/serial_output_register.sv
// LSB-first parallel-to-serial transmitter with a one-entry holding buffer; bit0 is valid the cycle after accept.
// A word offered while the holding buffer is full waits (in_ready low) until the shifting word finishes.
module serial_output_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             word_done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shift_reg, shift_nxt;
    logic [WIDTH-1:0]   hold_reg, hold_nxt;
    logic               hold_full, hold_full_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               accept;

    assign in_ready = ~hold_full;
    assign accept   = in_valid & in_ready;
    assign busy     = (state == SHIFT) | hold_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            hold_reg  <= hold_nxt;
            hold_full <= hold_full_nxt;
            count     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        hold_nxt      = hold_reg;
        hold_full_nxt = hold_full;
        count_nxt     = count;
        serial_out    = 1'b0;
        serial_valid  = 1'b0;
        word_done     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_nxt = data_in;
                    count_nxt = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                serial_out   = shift_reg[0];
                serial_valid = 1'b1;
                shift_nxt    = shift_reg >> 1;
                if (count == LAST) begin
                    // buffered word wins over a fresh offer; in_ready is low then anyway
                    word_done = 1'b1;
                    count_nxt = '0;
                    if (hold_full) begin
                        shift_nxt     = hold_reg;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        shift_nxt = data_in;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                    if (accept) begin
                        hold_nxt      = data_in;
                        hold_full_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_output_register.sv
// Bench for serial_output_register: WIDTH=4 against a queue-of-bits model, plus a WIDTH=8 mid-frame reset case.
module tb_serial_output_register;
    logic       clk = 1'b0;
    logic       rst_n, rst8_n;
    logic [3:0] dat4;
    logic       vld4, rdy4, so4, sv4, busy4, wd4;
    logic [7:0] dat8;
    logic       vld8, rdy8, so8, sv8, busy8, wd8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: bits still to be sent for the current word, plus one buffered word
    bit       m_cur[$];
    bit [3:0] m_hold;
    bit       m_hold_v;

    bit       q4[$];
    int       d4[$];
    int       c4[$];
    logic [3:0] rx4;
    bit       q8[$];
    int       d8[$];
    logic [7:0] rx8;

    always #5 clk = ~clk;

    serial_output_register #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(rst_n), .data_in(dat4), .in_valid(vld4), .in_ready(rdy4),
        .serial_out(so4), .serial_valid(sv4), .busy(busy4), .word_done(wd4)
    );

    serial_output_register #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(rst8_n), .data_in(dat8), .in_valid(vld8), .in_ready(rdy8),
        .serial_out(so8), .serial_valid(sv8), .busy(busy8), .word_done(wd8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_cur.delete();
        m_hold   = '0;
        m_hold_v = 1'b0;
    endfunction

    function automatic void m_load(input bit [3:0] w);
        for (int i = 0; i < 4; i++) m_cur.push_back(w[i]);
    endfunction

    function automatic void m_edge(input bit [3:0] w, input bit acc);
        bit had;
        had = (m_cur.size() != 0);
        if (had) void'(m_cur.pop_front());
        if (!had) begin
            if (acc) m_load(w);
        end else if (m_cur.size() == 0) begin
            if (m_hold_v) begin
                m_load(m_hold);
                m_hold_v = 1'b0;
            end else if (acc) begin
                m_load(w);
            end
        end else if (acc) begin
            m_hold   = w;
            m_hold_v = 1'b1;
        end
    endfunction

    task automatic step4();
        bit acc;
        @(negedge clk);
        chk("sv4", sv4, m_cur.size() != 0);
        chk("so4", so4, (m_cur.size() != 0) ? m_cur[0] : 1'b0);
        chk("wd4", wd4, m_cur.size() == 1);
        chk("rdy4", rdy4, !m_hold_v);
        chk("busy4", busy4, (m_cur.size() != 0) || m_hold_v);
        if (sv4 === 1'b1) begin
            q4.push_back(so4);
            d4.push_back(int'(wd4));
            c4.push_back(cyc);
            rx4 = {so4, rx4[3:1]};
        end
        acc = vld4 && !m_hold_v;
        @(posedge clk);
        if (rst_n) m_edge(dat4, acc);
        cyc++;
        #1;
    endtask

    task automatic step8();
        @(negedge clk);
        if (sv8 === 1'b1) begin
            q8.push_back(so8);
            d8.push_back(int'(wd8));
            rx8 = {so8, rx8[7:1]};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr4();
        q4.delete(); d4.delete(); c4.delete();
    endtask

    initial begin
        logic [3:0] w;
        logic [7:0] w8;
        logic [3:0] bp_words [3];
        bp_words = '{4'h3, 4'hC, 4'hF};
        rst_n = 1'b0; rst8_n = 1'b0;
        dat4 = '0; vld4 = 1'b0; dat8 = '0; vld8 = 1'b0;
        rx4 = '0; rx8 = '0;
        m_reset();

        // reset: outputs quiet, in_ready high, handshakes ignored
        #1;
        chk("rst_sv", sv4, 1'b0);
        chk("rst_rdy", rdy4, 1'b1);
        vld4 = 1'b1; dat4 = 4'hF;
        step4();
        vld4 = 1'b0;
        step4();
        step4();
        rst_n = 1'b1; rst8_n = 1'b1;
        for (int i = 0; i < 5; i++) step4();

        // single word 1011
        clr4();
        dat4 = 4'b1011; vld4 = 1'b1;
        step4();
        vld4 = 1'b0; dat4 = 4'h0;
        for (int i = 0; i < 6; i++) step4();
        chk("single_n", q4.size(), 4);
        w = 4'b1011;
        for (int i = 0; i < 4 && i < q4.size(); i++) begin
            chk("single_bit", q4[i], w[i]);
            chk("single_done", d4[i], i == 3);
        end
        chk("loopback", rx4, 4'b1011);
        chk("single_idle", busy4, 1'b0);

        // back-to-back A then 5
        clr4();
        dat4 = 4'hA; vld4 = 1'b1;
        step4();
        dat4 = 4'h5;
        step4();
        vld4 = 1'b0;
        for (int i = 0; i < 10; i++) step4();
        chk("b2b_n", q4.size(), 8);
        for (int i = 0; i < 8 && i < q4.size(); i++) begin
            w = (i < 4) ? 4'hA : 4'h5;
            chk("b2b_bit", q4[i], w[i % 4]);
            chk("b2b_done", d4[i], (i % 4) == 3);
        end
        if (q4.size() == 8) chk("b2b_contig", c4[7] - c4[0], 7);

        // backpressure: 3 shifting, C buffered, F waits
        clr4();
        dat4 = 4'h3; vld4 = 1'b1;
        step4();
        dat4 = 4'hC;
        step4();
        dat4 = 4'hF;
        chk("bp_rdy_low", rdy4, 1'b0);
        for (int i = 0; i < 4; i++) step4();
        vld4 = 1'b0;
        for (int i = 0; i < 12; i++) step4();
        chk("bp_n", q4.size(), 12);
        for (int i = 0; i < 12 && i < q4.size(); i++) begin
            w = bp_words[i / 4];
            chk("bp_bit", q4[i], w[i % 4]);
        end
        if (q4.size() == 12) chk("bp_contig", c4[11] - c4[0], 11);

        // random traffic with one mid-stream reset
        for (int i = 0; i < 300; i++) begin
            vld4 = ($urandom_range(0, 3) != 0);
            dat4 = 4'($urandom);
            if (i == 150) begin
                rst_n = 1'b0;
                m_reset();
                #1;
                chk("rnd_rst_sv", sv4, 1'b0);
            end
            if (i == 152) rst_n = 1'b1;
            step4();
        end

        // WIDTH=8: reset after 3 bits of A5, then 3C
        dat8 = 8'hA5; vld8 = 1'b1;
        step8();
        vld8 = 1'b0;
        for (int i = 0; i < 3; i++) step8();
        chk("w8_pre_n", q8.size(), 3);
        w8 = 8'hA5;
        for (int i = 0; i < 3 && i < q8.size(); i++) chk("w8_pre_bit", q8[i], w8[i]);
        chk("w8_pre_sv", sv8, 1'b1);
        rst8_n = 1'b0;
        #1;
        chk("w8_rst_sv", sv8, 1'b0);
        chk("w8_rst_busy", busy8, 1'b0);
        chk("w8_rst_so", so8, 1'b0);
        chk("w8_rst_rdy", rdy8, 1'b1);
        q8.delete(); d8.delete();
        step8();
        rst8_n = 1'b1;
        step8();
        chk("w8_rst_nobits", q8.size(), 0);
        dat8 = 8'h3C; vld8 = 1'b1;
        step8();
        vld8 = 1'b0; dat8 = 8'hFF;
        for (int i = 0; i < 10; i++) step8();
        chk("w8_n", q8.size(), 8);
        w8 = 8'h3C;
        for (int i = 0; i < 8 && i < q8.size(); i++) begin
            chk("w8_bit", q8[i], w8[i]);
            chk("w8_done", d8[i], i == 7);
        end
        chk("w8_loopback", rx8, 8'h3C);
        chk("w8_idle", busy8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
